// File: rtl/fetch_unit.sv
// Instruction-fetch stage sitting between the PC register and the instruction queue.
// Keeps at most one instruction-memory read in flight. Pushes each returned word and
// its PC into the queue. Drops stale fetches whenever the PC is redirected.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [3:0]        imem_rmask,
  input  logic              imem_resp,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              iq_full,
  output logic              iq_push,
  output logic [INST_W-1:0] iq_inst,
  output logic [ADDR_W-1:0] iq_pc,
  output logic              request_new_inst,
  output logic              fetch_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] req_pc_reg;
  logic [INST_W-1:0] hold_inst_reg;
  logic [ADDR_W-1:0] hold_pc_reg;

  logic push_from_mem;
  logic push_from_hold;

  // Push decisions: a live response with room in the queue, or a buffered word once
  // the queue drains. A redirect in the same cycle always suppresses the push. A reset
  // cycle also suppresses it, so that nothing escapes while the block is reset.
  always_comb begin
    push_from_mem  = rst && (state_reg == WAIT) && imem_resp && !redirect && !iq_full;
    push_from_hold = rst && (state_reg == HOLD) && !redirect && !iq_full;
  end

  // Queue-side outputs. The data comes from the hold buffer in HOLD and from memory otherwise.
  always_comb begin
    iq_push          = push_from_mem || push_from_hold;
    request_new_inst = iq_push;
    iq_inst          = (state_reg == HOLD) ? hold_inst_reg : imem_rdata;
    iq_pc            = (state_reg == HOLD) ? hold_pc_reg   : req_pc_reg;
    fetch_busy       = (state_reg != IDLE);
  end

  // Fetch FSM with the registered memory request outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      imem_addr     <= '0;
      imem_rmask    <= 4'h0;
      req_pc_reg    <= '0;
      hold_inst_reg <= '0;
      hold_pc_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Issue only when the queue has room and the pc is not about to change.
          // A late response arriving here belongs to nothing and is ignored.
          if (!iq_full && !redirect) begin
            imem_addr  <= pc;
            req_pc_reg <= pc;
            imem_rmask <= 4'hF;
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp) begin
            imem_rmask <= 4'h0;
            if (!redirect && iq_full) begin
              hold_inst_reg <= imem_rdata;
              hold_pc_reg   <= req_pc_reg;
              state_reg     <= HOLD;
            end else begin
              // The word was either pushed this cycle or dropped because of a redirect.
              state_reg <= IDLE;
            end
          end else if (redirect) begin
            // The outstanding read cannot be cancelled. Its response must be swallowed.
            state_reg <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_resp) begin
            imem_rmask <= 4'h0;
            state_reg  <= IDLE;
          end
        end
        HOLD: begin
          if (redirect || !iq_full) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit. Each table row gives the inputs for one
// cycle and the outputs expected during that cycle, before the next rising edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        iq_full;
  logic        iq_push;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        request_new_inst;
  logic        fetch_busy;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(32), .INST_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .redirect         (redirect),
    .imem_addr        (imem_addr),
    .imem_rmask       (imem_rmask),
    .imem_resp        (imem_resp),
    .imem_rdata       (imem_rdata),
    .iq_full          (iq_full),
    .iq_push          (iq_push),
    .iq_inst          (iq_inst),
    .iq_pc            (iq_pc),
    .request_new_inst (request_new_inst),
    .fetch_busy       (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        redir;
    logic        resp;
    logic [31:0] rdata;
    logic        full;
    logic        chk;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic        push;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        busy;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;

  task automatic add(input logic r, input logic [31:0] p, input logic rd, input logic rs,
                     input logic [31:0] dat, input logic f, input logic c,
                     input logic [31:0] a, input logic [3:0] m, input logic ps,
                     input logic [31:0] ins, input logic [31:0] ip, input logic b);
    vecs[nvec] = '{rst:r, pc:p, redir:rd, resp:rs, rdata:dat, full:f, chk:c,
                   addr:a, rmask:m, push:ps, inst:ins, ipc:ip, busy:b};
    nvec++;
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [31:0] p;
    rst = 1'b0; pc = '0; redirect = 1'b0; imem_resp = 1'b0; imem_rdata = '0; iq_full = 1'b0;

    //    rst pc            rd rs rdata         f  chk addr          rm    ps inst          ipc           busy
    add(0, 32'h6000_0000, 0, 0, 32'h0,         0, 0, 32'h0,        4'h0, 0, 32'h0,        32'h0,        0); // 0 reset edge
    add(0, 32'h6000_0000, 0, 0, 32'h0,         0, 1, 32'h0,        4'h0, 0, 32'h0,        32'h0,        0); // 1 reset state
    add(1, 32'h6000_0000, 0, 0, 32'h0,         0, 1, 32'h0,        4'h0, 0, 32'h0,        32'h0,        0); // 2 IDLE issues
    add(1, 32'h6000_0000, 0, 1, 32'h0000_0013, 0, 1, 32'h6000_0000,4'hF, 1, 32'h13,       32'h6000_0000,1); // 3 1-cycle resp
    add(1, 32'h6000_0004, 0, 0, 32'h0,         0, 1, 32'h6000_0000,4'h0, 0, 32'h0,        32'h0,        0); // 4 IDLE
    add(1, 32'h6000_0004, 0, 0, 32'h0,         0, 1, 32'h6000_0004,4'hF, 0, 32'h0,        32'h0,        1); // 5 WAIT
    add(1, 32'h6000_0004, 0, 1, 32'h0000_0093, 0, 1, 32'h6000_0004,4'hF, 1, 32'h93,       32'h6000_0004,1); // 6 resp
    add(1, 32'h6000_0008, 0, 0, 32'h0,         0, 1, 32'h6000_0004,4'h0, 0, 32'h0,        32'h0,        0); // 7 IDLE
    add(1, 32'h6000_0008, 0, 0, 32'h0,         0, 1, 32'h6000_0008,4'hF, 0, 32'h0,        32'h0,        1); // 8 WAIT
    add(1, 32'h6000_0008, 0, 0, 32'h0,         0, 1, 32'h6000_0008,4'hF, 0, 32'h0,        32'h0,        1); // 9 WAIT
    add(1, 32'h6000_0008, 0, 1, 32'h0010_0113, 1, 1, 32'h6000_0008,4'hF, 0, 32'h0,        32'h0,        1); // 10 resp, full
    add(1, 32'h6000_0008, 0, 0, 32'h0,         1, 1, 32'h6000_0008,4'h0, 0, 32'h0,        32'h0,        1); // 11 HOLD
    add(1, 32'h6000_0008, 0, 0, 32'h0,         1, 1, 32'h6000_0008,4'h0, 0, 32'h0,        32'h0,        1); // 12 HOLD
    add(1, 32'h6000_0008, 0, 0, 32'hBAD0_BAD0, 0, 1, 32'h6000_0008,4'h0, 1, 32'h0010_0113,32'h6000_0008,1); // 13 drain
    for (int k = 0; k < 5; k++)
      add(1, 32'h6000_000C, 0, 0, 32'h0,       1, 1, 32'h6000_0008,4'h0, 0, 32'h0,        32'h0,        0); // 14-18 full
    add(1, 32'h6000_000C, 0, 0, 32'h0,         0, 1, 32'h6000_0008,4'h0, 0, 32'h0,        32'h0,        0); // 19 issue
    add(1, 32'h6000_000C, 1, 0, 32'h0,         0, 1, 32'h6000_000C,4'hF, 0, 32'h0,        32'h0,        1); // 20 redirect
    add(1, 32'h6000_0100, 0, 0, 32'h0,         0, 1, 32'h6000_000C,4'hF, 0, 32'h0,        32'h0,        1); // 21 DISCARD
    add(1, 32'h6000_0100, 1, 0, 32'h0,         0, 1, 32'h6000_000C,4'hF, 0, 32'h0,        32'h0,        1); // 22 DISCARD
    add(1, 32'h6000_0100, 0, 1, 32'hDEAD_BEEF, 0, 1, 32'h6000_000C,4'hF, 0, 32'h0,        32'h0,        1); // 23 dropped
    add(1, 32'h6000_0100, 0, 0, 32'h0,         0, 1, 32'h6000_000C,4'h0, 0, 32'h0,        32'h0,        0); // 24 IDLE
    add(1, 32'h6000_0100, 0, 0, 32'h0,         0, 1, 32'h6000_0100,4'hF, 0, 32'h0,        32'h0,        1); // 25 WAIT
    add(1, 32'h6000_0100, 1, 1, 32'h1111_1111, 0, 1, 32'h6000_0100,4'hF, 0, 32'h0,        32'h0,        1); // 26 resp+redir
    add(1, 32'h6000_0200, 0, 0, 32'h0,         0, 1, 32'h6000_0100,4'h0, 0, 32'h0,        32'h0,        0); // 27 IDLE
    add(0, 32'h6000_0200, 0, 0, 32'h0,         0, 1, 32'h6000_0200,4'hF, 0, 32'h0,        32'h0,        1); // 28 reset in WAIT
    add(1, 32'h6000_0200, 0, 1, 32'h2222_2222, 0, 1, 32'h0,        4'h0, 0, 32'h0,        32'h0,        0); // 29 late resp
    add(1, 32'h6000_0200, 0, 0, 32'h0,         0, 1, 32'h6000_0200,4'hF, 0, 32'h0,        32'h0,        1); // 30 WAIT
    add(1, 32'h6000_0200, 0, 1, 32'h3333_3333, 1, 1, 32'h6000_0200,4'hF, 0, 32'h0,        32'h0,        1); // 31 to HOLD
    add(1, 32'h6000_0200, 1, 0, 32'h0,         0, 1, 32'h6000_0200,4'h0, 0, 32'h0,        32'h0,        1); // 32 redirect wins
    add(1, 32'h6000_0300, 0, 0, 32'h0,         0, 1, 32'h6000_0200,4'h0, 0, 32'h0,        32'h0,        0); // 33 IDLE
    add(1, 32'h6000_0300, 0, 0, 32'h0,         0, 1, 32'h6000_0300,4'hF, 0, 32'h0,        32'h0,        1); // 34 WAIT
    add(1, 32'h6000_0300, 0, 1, 32'h0000_0044, 0, 1, 32'h6000_0300,4'hF, 1, 32'h44,       32'h6000_0300,1); // 35 push

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      pc         = vecs[i].pc;
      redirect   = vecs[i].redir;
      imem_resp  = vecs[i].resp;
      imem_rdata = vecs[i].rdata;
      iq_full    = vecs[i].full;
      #1;
      if (vecs[i].chk) begin
        cmp("imem_addr",  i, imem_addr, vecs[i].addr);
        cmp("imem_rmask", i, {28'h0, imem_rmask}, {28'h0, vecs[i].rmask});
        cmp("iq_push",    i, {31'h0, iq_push}, {31'h0, vecs[i].push});
        cmp("request_new_inst", i, {31'h0, request_new_inst}, {31'h0, vecs[i].push});
        cmp("fetch_busy", i, {31'h0, fetch_busy}, {31'h0, vecs[i].busy});
        if (vecs[i].push) begin
          cmp("iq_inst", i, iq_inst, vecs[i].inst);
          cmp("iq_pc",   i, iq_pc,   vecs[i].ipc);
        end
      end
      $display("row %0d rst=%0b pc=%h redir=%0b resp=%0b full=%0b -> addr=%h rmask=%h push=%0b busy=%0b",
               i, rst, pc, redirect, imem_resp, iq_full, imem_addr, imem_rmask, iq_push, fetch_busy);
    end

    // Back-to-back fetches from a memory that answers at once: one push every 2 cycles.
    p = 32'h6000_0304;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pc = p; redirect = 1'b0; imem_resp = 1'b0; iq_full = 1'b0; rst = 1'b1;
      #1;
      cmp("b2b_idle_rmask", 100 + k, {28'h0, imem_rmask}, 32'h0);
      cmp("b2b_idle_push",  100 + k, {31'h0, iq_push}, 32'h0);
      @(negedge clk);
      imem_resp = 1'b1; imem_rdata = 32'h0000_1000 + k;
      #1;
      cmp("b2b_addr", 100 + k, imem_addr, p);
      cmp("b2b_push", 100 + k, {31'h0, iq_push}, 32'h1);
      cmp("b2b_inst", 100 + k, iq_inst, 32'h0000_1000 + k);
      cmp("b2b_pc",   100 + k, iq_pc, p);
      $display("b2b %0d addr=%h push=%0b inst=%h pc=%h", k, imem_addr, iq_push, iq_inst, iq_pc);
      p = p + 32'd4;
    end
    @(negedge clk);
    imem_resp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
